// File: rtl/credit_vc_arbiter_pkg.sv
// Shared chiplet types for the credit-based VC arbiter: flit type and credit-width helper.
package credit_vc_arbiter_pkg;
   localparam int FLIT_W  = 32;
   localparam int STALL_W = 16;

   typedef logic [FLIT_W-1:0] flit_t;

   // Counter must hold 0..buffer_size inclusive
   function automatic int cred_w(input int buffer_size);
      return $clog2(buffer_size + 1);
   endfunction
endpackage

// File: rtl/credit_vc_arbiter_if.sv
// Link-side bundle of the VC arbiter: requester inputs, link output, credit return and status.
interface credit_vc_arbiter_if #(
   parameter int NUM_VCS     = 2,
   parameter int BUFFER_SIZE = 8
);
   import credit_vc_arbiter_pkg::*;
   localparam int CRED_W = cred_w(BUFFER_SIZE);

   logic  [NUM_VCS-1:0]                req;
   flit_t [NUM_VCS-1:0]                flit_in;
   flit_t                              out;
   logic                               data_ready_out;
   logic                               packet_sent;
   logic  [NUM_VCS-1:0]                credit_granted;
   logic  [NUM_VCS-1:0]                grant;
   logic  [NUM_VCS-1:0][CRED_W-1:0]    credits;
   logic                               credit_err;
   logic  [NUM_VCS-1:0][STALL_W-1:0]   stall_count;

   modport master (
      output req, flit_in, packet_sent, credit_granted,
      input  out, data_ready_out, grant, credits, credit_err, stall_count
   );

   modport slave (
      input  req, flit_in, packet_sent, credit_granted,
      output out, data_ready_out, grant, credits, credit_err, stall_count
   );
endinterface

// File: rtl/credit_vc_arbiter_rr_select.sv
// Round-robin picker: first set request at or after ptr, wrapping, as a one-hot vector.
module rr_select
   import credit_vc_arbiter_pkg::*;
#(
   parameter  int N  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic          valid
);
   always_comb begin
      onehot = '0;
      valid  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!valid && req[(int'(ptr) + i) % N]) begin
            onehot[(int'(ptr) + i) % N] = 1'b1;
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/credit_vc_arbiter.sv
// Credit-based virtual-channel arbiter onto one link; optional stall counters under
// CREDIT_VC_ARBITER_STALL_CNT_EN.
module credit_vc_arbiter
   import credit_vc_arbiter_pkg::*;
#(
   parameter int NUM_VCS     = 2,
   parameter int BUFFER_SIZE = 8
) (
   input  logic          clk,
   input  logic          n_rst,
   credit_vc_arbiter_if.slave bus
);
   localparam int CRED_W = cred_w(BUFFER_SIZE);
   localparam int VW     = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                          state, next_state;
   logic   [VW-1:0]                 cur_vc, rr_ptr, sel_idx;
   logic   [NUM_VCS-1:0]            eligible, sel_onehot, grant, cred_dec;
   logic                            sel_valid, load, send_done, credit_err;
   flit_t                           out_q;
   logic   [NUM_VCS-1:0][CRED_W-1:0] credits;

   always_comb begin
      for (int v = 0; v < NUM_VCS; v++)
         eligible[v] = bus.req[v] && (credits[v] != '0);
   end

   rr_select #(.N(NUM_VCS)) u_rr (
      .req    (eligible),
      .ptr    (rr_ptr),
      .onehot (sel_onehot),
      .valid  (sel_valid)
   );

   always_comb begin
      sel_idx = '0;
      for (int v = 0; v < NUM_VCS; v++)
         if (sel_onehot[v]) sel_idx = VW'(v);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      send_done  = 1'b0;
      grant      = '0;
      case (state)
         IDLE: if (sel_valid) begin
            load       = 1'b1;
            next_state = SEND;
         end
         SEND: if (bus.packet_sent) begin
            send_done     = 1'b1;
            grant[cur_vc] = 1'b1;
            next_state    = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cur_vc <= '0;
         rr_ptr <= '0;
         out_q  <= '0;
      end else begin
         if (load) begin
            cur_vc <= sel_idx;
            out_q  <= bus.flit_in[sel_idx];
         end
         if (send_done)
            rr_ptr <= (cur_vc == VW'(NUM_VCS-1)) ? '0 : cur_vc + 1'b1;
      end
   end

   always_comb begin
      for (int v = 0; v < NUM_VCS; v++)
         cred_dec[v] = send_done && (cur_vc == VW'(v));
   end

   // A return and a consume on the same VC cancel; overflow saturates and latches the error
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int v = 0; v < NUM_VCS; v++) credits[v] <= CRED_W'(BUFFER_SIZE);
         credit_err <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VCS; v++) begin
            if (bus.credit_granted[v] && !cred_dec[v]) begin
               if (credits[v] == CRED_W'(BUFFER_SIZE)) credit_err <= 1'b1;
               else                                    credits[v] <= credits[v] + 1'b1;
            end else if (cred_dec[v] && !bus.credit_granted[v]) begin
               credits[v] <= credits[v] - 1'b1;
            end
         end
      end
   end

`ifdef CREDIT_VC_ARBITER_STALL_CNT_EN
   logic [NUM_VCS-1:0][STALL_W-1:0] stall_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) stall_q <= '0;
      else begin
         for (int v = 0; v < NUM_VCS; v++)
            if (bus.req[v] && (credits[v] == '0) && (stall_q[v] != '1))
               stall_q[v] <= stall_q[v] + 1'b1;
      end
   end

   assign bus.stall_count = stall_q;
`else
   assign bus.stall_count = '0;
`endif

   assign bus.out            = out_q;
   assign bus.data_ready_out = (state == SEND);
   assign bus.grant          = grant;
   assign bus.credits        = credits;
   assign bus.credit_err     = credit_err;
endmodule

// File: tb/tb_credit_vc_arbiter.sv
// Directed bench for credit_vc_arbiter: vector table plus multi-cycle credit/reset sequences.
module tb_credit_vc_arbiter;
   import credit_vc_arbiter_pkg::*;

   localparam int    NV = 2;
   localparam int    BS = 8;
   localparam flit_t F0 = 32'hA0A0_0001;
   localparam flit_t F1 = 32'hB1B1_0002;
`ifdef CREDIT_VC_ARBITER_STALL_CNT_EN
   localparam logic [31:0] EXP_STALL5 = 32'd5;
`else
   localparam logic [31:0] EXP_STALL5 = 32'd0;
`endif

   logic clk = 1'b0;
   logic n_rst;
   int   total  = 0;
   int   passed = 0;

   credit_vc_arbiter_if #(.NUM_VCS(NV), .BUFFER_SIZE(BS)) bus ();

   credit_vc_arbiter #(.NUM_VCS(NV), .BUFFER_SIZE(BS)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic       ps;
      logic [1:0] cg;
      logic       dro;
      flit_t      out;
      logic [1:0] grant;
      logic [3:0] c0;
      logic [3:0] c1;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] r, input logic ps, input logic [1:0] cg);
      bus.req            = r;
      bus.packet_sent    = ps;
      bus.credit_granted = cg;
   endtask

   task automatic do_reset;
      n_rst = 1'b0;
      drive(2'b00, 1'b0, 2'b00);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   initial begin
      vec_t tbl[11];
      bus.flit_in[0] = F0;
      bus.flit_in[1] = F1;
      do_reset();

      chk("rst dro",    32'(bus.data_ready_out), 32'd0);
      chk("rst out",    bus.out,                 32'd0);
      chk("rst grant",  32'(bus.grant),          32'd0);
      chk("rst cred0",  32'(bus.credits[0]),     32'd8);
      chk("rst cred1",  32'(bus.credits[1]),     32'd8);
      chk("rst err",    32'(bus.credit_err),     32'd0);
      chk("rst stall0", 32'(bus.stall_count[0]), 32'd0);

      // Observed values are those seen mid-cycle with the row's inputs applied
      tbl[0]  = '{2'b01, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 4'd8, 4'd8};
      tbl[1]  = '{2'b01, 1'b1, 2'b00, 1'b1, F0,    2'b01, 4'd8, 4'd8};
      tbl[2]  = '{2'b11, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 4'd7, 4'd8};
      tbl[3]  = '{2'b11, 1'b1, 2'b00, 1'b1, F1,    2'b10, 4'd7, 4'd8};
      tbl[4]  = '{2'b11, 1'b1, 2'b00, 1'b0, 32'h0, 2'b00, 4'd7, 4'd7};
      tbl[5]  = '{2'b11, 1'b0, 2'b00, 1'b1, F0,    2'b00, 4'd7, 4'd7};
      tbl[6]  = '{2'b11, 1'b1, 2'b00, 1'b1, F0,    2'b01, 4'd7, 4'd7};
      tbl[7]  = '{2'b11, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 4'd6, 4'd7};
      tbl[8]  = '{2'b00, 1'b1, 2'b00, 1'b1, F1,    2'b10, 4'd6, 4'd7};
      tbl[9]  = '{2'b00, 1'b0, 2'b11, 1'b0, 32'h0, 2'b00, 4'd6, 4'd6};
      tbl[10] = '{2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 4'd7, 4'd7};

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].req, tbl[i].ps, tbl[i].cg);
         #2;
         chk($sformatf("vec%0d dro", i),   32'(bus.data_ready_out), 32'(tbl[i].dro));
         if (tbl[i].dro) chk($sformatf("vec%0d out", i), bus.out, tbl[i].out);
         chk($sformatf("vec%0d grant", i), 32'(bus.grant),      32'(tbl[i].grant));
         chk($sformatf("vec%0d cred0", i), 32'(bus.credits[0]), 32'(tbl[i].c0));
         chk($sformatf("vec%0d cred1", i), 32'(bus.credits[1]), 32'(tbl[i].c1));
         tick();
      end

      // Exhaust VC0 credits, confirm it blocks while VC1 is served, then return one credit
      do_reset();
      for (int n = 0; n < 8; n++) begin
         drive(2'b01, 1'b0, 2'b00);
         tick();
         drive(2'b01, 1'b1, 2'b00);
         #1;
         chk($sformatf("drain%0d grant", n), 32'(bus.grant), 32'd1);
         tick();
      end
      drive(2'b01, 1'b0, 2'b00);
      #1;
      chk("drain cred0", 32'(bus.credits[0]), 32'd0);
      repeat (5) tick();
      chk("blocked dro", 32'(bus.data_ready_out), 32'd0);
      chk("stall0 x5",   32'(bus.stall_count[0]), EXP_STALL5);
      drive(2'b11, 1'b0, 2'b00);
      tick();
      chk("vc1 dro", 32'(bus.data_ready_out), 32'd1);
      chk("vc1 out", bus.out, F1);
      drive(2'b11, 1'b1, 2'b00);
      #1;
      chk("vc1 grant", 32'(bus.grant), 32'd2);
      tick();
      drive(2'b01, 1'b0, 2'b01);
      tick();
      drive(2'b01, 1'b0, 2'b00);
      chk("ret cred0", 32'(bus.credits[0]), 32'd1);
      chk("ret dro",   32'(bus.data_ready_out), 32'd0);
      tick();
      chk("vc0 again dro", 32'(bus.data_ready_out), 32'd1);
      chk("vc0 again out", bus.out, F0);
      drive(2'b01, 1'b1, 2'b00);
      #1;
      chk("vc0 again grant", 32'(bus.grant), 32'd1);
      tick();
      chk("vc0 again cred0", 32'(bus.credits[0]), 32'd0);

      // Overflow saturates and the error sticks until reset
      do_reset();
      drive(2'b00, 1'b0, 2'b01);
      tick();
      drive(2'b00, 1'b0, 2'b00);
      chk("ovf cred0", 32'(bus.credits[0]), 32'd8);
      chk("ovf err",   32'(bus.credit_err), 32'd1);
      repeat (3) tick();
      chk("ovf err sticky", 32'(bus.credit_err), 32'd1);
      do_reset();
      chk("ovf err cleared", 32'(bus.credit_err), 32'd0);

      // Consume and return on the same VC cancel; reset mid-send drops the flit cleanly
      drive(2'b01, 1'b0, 2'b00);
      tick();
      drive(2'b01, 1'b1, 2'b01);
      #1;
      chk("cancel grant", 32'(bus.grant), 32'd1);
      tick();
      drive(2'b00, 1'b0, 2'b00);
      chk("cancel cred0", 32'(bus.credits[0]), 32'd8);
      drive(2'b01, 1'b0, 2'b00);
      tick();
      chk("pre-rst dro", 32'(bus.data_ready_out), 32'd1);
      drive(2'b01, 1'b1, 2'b00);
      #1;
      n_rst = 1'b0;
      #1;
      chk("midrst dro",   32'(bus.data_ready_out), 32'd0);
      chk("midrst grant", 32'(bus.grant),          32'd0);
      chk("midrst cred0", 32'(bus.credits[0]),     32'd8);
      drive(2'b00, 1'b0, 2'b00);
      tick();
      n_rst = 1'b1;
      tick();
      chk("post-rst cred0", 32'(bus.credits[0]), 32'd8);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
